// File: rtl/mat_pkg.sv
// mat_pkg: shared types and constants for the matrix streaming stages.
package mat_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   localparam int RD_LAT     = 2;
   localparam int FIFO_DEPTH = 4;
   localparam int FIFO_AW    = $clog2(FIFO_DEPTH);
   localparam int FIFO_CW    = $clog2(FIFO_DEPTH + 1);
endpackage

// File: rtl/mat_rd_stream_if.sv
// mat_rd_stream_if: valid/ready element stream carrying line and matrix end markers.
interface mat_rd_stream_if #(parameter int DATA = 16);
   logic [DATA-1:0] data;
   logic            valid;
   logic            ready;
   logic            last;
   logic            eom;
   modport master (output data, valid, last, eom, input ready);
   modport slave  (input data, valid, last, eom, output ready);
endinterface

// File: rtl/mat_rd_fifo.sv
// mat_rd_fifo: FIFO_DEPTH-entry synchronous FIFO with occupancy count.
module mat_rd_fifo
   import mat_pkg::*;
#(
   parameter int W = 18
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_push,
   input  logic [W-1:0]       i_din,
   input  logic               i_pop,
   output logic [W-1:0]       o_dout,
   output logic               o_empty,
   output logic [FIFO_CW-1:0] o_count
);
   localparam logic [FIFO_CW-1:0] FULL = FIFO_CW'(FIFO_DEPTH);
   logic [W-1:0]       r_mem [FIFO_DEPTH];
   logic [FIFO_AW-1:0] r_wp, r_rp;
   logic [FIFO_CW-1:0] r_cnt;
   logic               w_push, w_pop;
   assign w_push  = i_push && r_cnt != FULL;
   assign w_pop   = i_pop && r_cnt != '0;
   assign o_dout  = r_mem[r_rp];
   assign o_empty = r_cnt == '0;
   assign o_count = r_cnt;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         r_wp  <= w_push ? r_wp + FIFO_AW'(1) : r_wp;
         r_rp  <= w_pop ? r_rp + FIFO_AW'(1) : r_rp;
         r_cnt <= r_cnt + FIFO_CW'(w_push) - FIFO_CW'(w_pop);
      end
   end
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wp] <= i_din;
   end
endmodule

// File: rtl/mat_rd_stream.sv
// mat_rd_stream: streams a whole matrix from RAM port B as a valid/ready element stream.
// Define MAT_RD_TRANSPOSE_EN to add the transpose input for column-major traversal.
module mat_rd_stream
   import mat_pkg::*;
#(
   parameter int DATA = 16,
   parameter int ADDR = 5,
   parameter int COLB = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
`ifdef MAT_RD_TRANSPOSE_EN
   input  logic            transpose,
`endif
   output logic            busy,
   output logic            done,
   output logic [ADDR-1:0] ram_addr,
   output logic            ram_we,
   input  logic [DATA-1:0] ram_dout,
   mat_rd_stream_if.master m
);
   localparam int ROWB = ADDR - COLB;
   localparam logic [ADDR-1:0] LAST_IDX = '1;
   if (!(ADDR > COLB && COLB >= 1)) begin : g_bad_geometry
      $error("mat_rd_stream: ADDR > COLB >= 1 required");
   end
   state_t             r_state, w_state;
   logic [ADDR-1:0]    r_cnt, w_addr;
   logic [RD_LAT-1:0]  r_v, r_l, r_e;
   logic               w_tr, w_issue, w_credit, w_inner_last, w_drained;
   logic               w_empty;
   logic [FIFO_CW-1:0] w_count, w_occ;
   logic [DATA+1:0]    w_head;
`ifdef MAT_RD_TRANSPOSE_EN
   logic r_tr;
   assign w_tr = (r_state == IDLE) ? transpose : r_tr;
   always_ff @(posedge clk) begin
      if (rst) r_tr <= 1'b0;
      else if (r_state == IDLE && start) r_tr <= transpose;
   end
`else
   assign w_tr = 1'b0;
`endif
   // r_cnt is {outer, inner}; transposed passes swap the fields to form {row, col}
   assign w_addr       = w_tr ? {r_cnt[ROWB-1:0], r_cnt[ADDR-1:ROWB]} : r_cnt;
   assign w_inner_last = w_tr ? &r_cnt[ROWB-1:0] : &r_cnt[COLB-1:0];
   assign w_occ        = w_count + FIFO_CW'(r_v[0]) + FIFO_CW'(r_v[1]);
   assign w_credit     = w_occ < FIFO_CW'(FIFO_DEPTH);
   assign w_drained    = w_empty && r_v == '0;
   always_comb begin
      w_state = r_state;
      w_issue = 1'b0;
      done    = 1'b0;
      case (r_state)
         IDLE: begin
            w_issue = start;
            w_state = start ? RUN : IDLE;
         end
         RUN: begin
            w_issue = w_credit;
            w_state = (w_credit && r_cnt == LAST_IDX) ? DRAIN : RUN;
         end
         DRAIN: begin
            done    = w_drained;
            w_state = w_drained ? IDLE : DRAIN;
         end
         default: w_state = IDLE;
      endcase
   end
   // r_v[0]: address on the RAM bus this cycle; r_v[1]: RAM data valid this cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_v      <= '0;
         r_l      <= '0;
         r_e      <= '0;
         ram_addr <= '0;
      end else begin
         r_state  <= w_state;
         r_v      <= {r_v[0], w_issue};
         r_l      <= {r_l[0], w_issue && w_inner_last};
         r_e      <= {r_e[0], w_issue && r_cnt == LAST_IDX};
         r_cnt    <= w_issue ? r_cnt + ADDR'(1) : r_cnt;
         ram_addr <= w_issue ? w_addr : ram_addr;
      end
   end
   mat_rd_fifo #(.W(DATA + 2)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (r_v[1]),
      .i_din   ({r_e[1], r_l[1], ram_dout}),
      .i_pop   (m.valid && m.ready),
      .o_dout  (w_head),
      .o_empty (w_empty),
      .o_count (w_count)
   );
   assign busy    = r_state != IDLE;
   assign ram_we  = 1'b0;
   assign m.valid = !w_empty;
   assign m.data  = w_empty ? '0 : w_head[DATA-1:0];
   assign m.last  = !w_empty && w_head[DATA];
   assign m.eom   = !w_empty && w_head[DATA+1];
endmodule

// File: tb/tb_mat_rd_stream.sv
// tb_mat_rd_stream: directed checks of mat_rd_stream against a mem[i]=i RAM model.
module tb_mat_rd_stream;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        busy, done, ram_we;
   logic [4:0]  ram_addr;
   logic [15:0] ram_dout = '0;
   logic [15:0] mem [32];
   int          checks = 0;
   int          failures = 0;
`ifdef MAT_RD_TRANSPOSE_EN
   logic        transpose = 1'b0;
`endif
   mat_rd_stream_if #(.DATA(16)) m ();
   mat_rd_stream #(.DATA(16), .ADDR(5), .COLB(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
`ifdef MAT_RD_TRANSPOSE_EN
      .transpose (transpose),
`endif
      .busy      (busy),
      .done      (done),
      .ram_addr  (ram_addr),
      .ram_we    (ram_we),
      .ram_dout  (ram_dout),
      .m         (m.master)
   );
   always #5 clk = ~clk;
   always @(posedge clk) ram_dout <= mem[ram_addr];
   typedef struct {
      bit          valid;
      logic [15:0] data;
      bit          last;
      bit          eom;
      bit          done;
      bit          busy;
      logic [4:0]  addr;
   } vec_t;
   vec_t tbl [1:37];
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   function automatic int exp_addr(input int k, input bit tr);
      return tr ? (k % 4) * 8 + k / 4 : k;
   endfunction
   task automatic stream(input bit [3:0] rpat, input int stall0, input bit starts, input bit tr);
      int cyc, k, acc_cyc, dcnt, dcyc;
      bit pstall;
      logic [15:0] pd;
      k = 0; dcnt = 0; dcyc = -10; acc_cyc = -1; pstall = 0; pd = '0;
      start = 1'b1;
`ifdef MAT_RD_TRANSPOSE_EN
      transpose = tr;
`endif
      step();
      start = 1'b0;
      cyc = 1;
      while (cyc < 400 && !(dcnt > 0 && cyc > dcyc + 3)) begin
         start = starts && (cyc == 5 || cyc == 10);
         m.ready = (cyc <= stall0) ? 1'b0 : rpat[cyc % 4];
         if (pstall) begin
            chk("hold_valid", m.valid, 1);
            chk("hold_data", m.data, pd);
         end
         if (!tr && busy) chk("credit_le4", (int'(ram_addr) + 1 - k) <= 4, 1);
         if (stall0 > 0 && cyc == stall0) begin
            chk("stall_addr", ram_addr, 3);
            chk("stall_valid", m.valid, 1);
            chk("stall_data", m.data, 0);
         end
         if (done) begin
            dcnt++;
            dcyc = cyc;
         end
         if (m.valid && m.ready) begin
            chk("data", m.data, exp_addr(k, tr));
            chk("last", m.last, tr ? (k % 4 == 3) : (k % 8 == 7));
            chk("eom", m.eom, k == 31);
            if (k == 31) acc_cyc = cyc;
            k++;
         end
         pstall = m.valid && !m.ready;
         pd = m.data;
         step();
         cyc++;
      end
      m.ready = 1'b0;
      start = 1'b0;
      chk("elem_count", k, 32);
      chk("done_count", dcnt, 1);
      chk("done_cycle", dcyc, acc_cyc + 1);
   endtask
   initial begin
      int nd;
      m.ready = 1'b0;
      for (int i = 0; i < 32; i++) mem[i] = 16'(i);
      for (int c = 1; c <= 37; c++) begin
         tbl[c].valid = c >= 3 && c <= 34;
         tbl[c].data  = 16'(c - 3);
         tbl[c].last  = c >= 3 && c <= 34 && (c - 3) % 8 == 7;
         tbl[c].eom   = c == 34;
         tbl[c].done  = c == 35;
         tbl[c].busy  = c <= 35;
         tbl[c].addr  = (c <= 32) ? 5'(c - 1) : 5'd31;
      end
      repeat (3) step();
      rst = 1'b0;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_valid", m.valid, 0);
      chk("rst_last", m.last, 0);
      chk("rst_eom", m.eom, 0);
      chk("rst_addr", ram_addr, 0);
      chk("rst_data", m.data, 0);
      chk("ram_we", ram_we, 0);
      step();
      m.ready = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c <= 37; c++) begin
         chk("t_valid", m.valid, tbl[c].valid);
         if (tbl[c].valid) chk("t_data", m.data, tbl[c].data);
         chk("t_last", m.last, tbl[c].last);
         chk("t_eom", m.eom, tbl[c].eom);
         chk("t_done", done, tbl[c].done);
         chk("t_busy", busy, tbl[c].busy);
         chk("t_addr", ram_addr, tbl[c].addr);
         step();
      end
      m.ready = 1'b0;
      stream(4'b0011, 0, 1'b0, 1'b0);
      stream(4'b1111, 20, 1'b0, 1'b0);
      stream(4'b1111, 0, 1'b1, 1'b0);
      m.ready = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (11) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_busy", busy, 0);
      chk("mid_done", done, 0);
      chk("mid_valid", m.valid, 0);
      chk("mid_last", m.last, 0);
      chk("mid_eom", m.eom, 0);
      chk("mid_addr", ram_addr, 0);
      chk("mid_data", m.data, 0);
      nd = 0;
      for (int i = 0; i < 6; i++) begin
         if (done || m.valid) nd++;
         step();
      end
      chk("mid_quiet", nd, 0);
      m.ready = 1'b0;
      stream(4'b1111, 0, 1'b0, 1'b0);
`ifdef MAT_RD_TRANSPOSE_EN
      stream(4'b1111, 0, 1'b0, 1'b1);
      stream(4'b0011, 0, 1'b0, 1'b1);
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
